// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with a shared memory port for a MIPS-subset core.
// Optional performance counters are built when MULTICYCLE_CTRL_PERFCNT_EN is defined.
module multicycle_ctrl #(
    parameter int ACK_TIMEOUT = 0,
    parameter int TO_W        = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        memAck,
    output logic        memReq,
    output logic        memWe,
    output logic        memAddrSel,
    output logic        irWe,
    output logic        pcWe,
    output logic [1:0]  pcSrcCtrl,
    output logic        abWe,
    output logic        aluOutWe,
    output logic        mdrWe,
    output logic        regWe,
    output logic [1:0]  regDInCtrl,
    output logic [2:0]  state,
    output logic        halted,
    output logic [1:0]  haltCause,
    output logic [31:0] cycleCount,
    output logic [31:0] instrCount
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd7
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SLT   = 6'h2a;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

    localparam bit              WD_EN   = (ACK_TIMEOUT > 0);
    localparam logic [TO_W-1:0] WD_LAST = WD_EN ? TO_W'(ACK_TIMEOUT - 1) : '0;

    state_t          state_q, state_d;
    logic [1:0]      cause_q, cause_d;
    logic [TO_W-1:0] wd_q;
    logic            wd_expire;

    // Instruction class decode from the (stable) instruction register fields.
    logic is_lw, is_sw, is_j, is_jal, is_jr, is_beq, is_bne, is_imm, is_ralu, legal;

    always_comb begin
        is_lw   = (opcode == OP_LW);
        is_sw   = (opcode == OP_SW);
        is_j    = (opcode == OP_J);
        is_jal  = (opcode == OP_JAL);
        is_beq  = (opcode == OP_BEQ);
        is_bne  = (opcode == OP_BNE);
        is_imm  = (opcode == OP_ADDI) || (opcode == OP_XORI);
        is_jr   = (opcode == OP_RTYPE) && (funct == FN_JR);
        is_ralu = (opcode == OP_RTYPE) &&
                  ((funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_SLT));
        legal   = is_lw || is_sw || is_j || is_jal || is_beq || is_bne ||
                  is_imm || is_jr || is_ralu;
    end

    // Memory handshake: memReq/memWe/memAddrSel depend only on state (and the
    // held instruction), so they stay stable until memAck. memAck is honoured
    // only while memReq=1 and may arrive in the same cycle as the request;
    // in every other state it is ignored.
    logic       req_c, we_c, asel_c, ir_c, pc_c, ab_c, ao_c, mdr_c, rw_c;
    logic [1:0] pcs_c, rdc_c;

    assign wd_expire = WD_EN && (wd_q == WD_LAST);

    always_comb begin
        state_d = state_q;
        cause_d = CAUSE_NONE;
        req_c   = 1'b0;
        we_c    = 1'b0;
        asel_c  = 1'b0;
        ir_c    = 1'b0;
        pc_c    = 1'b0;
        pcs_c   = 2'd0;
        ab_c    = 1'b0;
        ao_c    = 1'b0;
        mdr_c   = 1'b0;
        rw_c    = 1'b0;
        rdc_c   = 2'd0;
        case (state_q)
            S_FETCH: begin
                req_c = 1'b1;
                if (memAck) begin
                    ir_c    = 1'b1;
                    pc_c    = 1'b1;
                    state_d = S_DECODE;
                end else if (wd_expire) begin
                    cause_d = CAUSE_TIMEOUT;
                    state_d = S_HALT;
                end
            end
            S_DECODE: begin
                ab_c = 1'b1;
                if (legal) begin
                    state_d = S_EXEC;
                end else begin
                    cause_d = CAUSE_ILLEGAL;
                    state_d = S_HALT;
                end
            end
            S_EXEC: begin
                ao_c    = 1'b1;
                state_d = S_FETCH;
                if (is_j || is_jal) begin
                    pc_c  = 1'b1;
                    pcs_c = 2'd1;
                    if (is_jal) begin
                        rw_c  = 1'b1;
                        rdc_c = 2'd2;
                    end
                end else if (is_jr) begin
                    pc_c  = 1'b1;
                    pcs_c = 2'd2;
                end else if (is_beq || is_bne) begin
                    pcs_c = 2'd3;
                    pc_c  = is_beq ? zero : !zero;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else if (is_ralu || is_imm) begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                req_c  = 1'b1;
                asel_c = 1'b1;
                we_c   = is_sw;
                if (memAck) begin
                    if (is_sw) begin
                        state_d = S_FETCH;
                    end else begin
                        mdr_c   = 1'b1;
                        state_d = S_WB;
                    end
                end else if (wd_expire) begin
                    cause_d = CAUSE_TIMEOUT;
                    state_d = S_HALT;
                end
            end
            S_WB: begin
                rw_c    = 1'b1;
                rdc_c   = is_lw ? 2'd1 : 2'd0;
                state_d = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            cause_q <= CAUSE_NONE;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            if ((state_d == S_HALT) && (state_q != S_HALT)) begin
                cause_q <= cause_d;
            end
            // Counter restarts for each new FETCH/MEM request.
            if (!WD_EN) begin
                wd_q <= '0;
            end else if ((state_d != state_q) &&
                         ((state_d == S_FETCH) || (state_d == S_MEM))) begin
                wd_q <= '0;
            end else if (req_c && !memAck) begin
                wd_q <= wd_q + 1'b1;
            end
        end
    end

`ifdef MULTICYCLE_CTRL_PERFCNT_EN
    logic [31:0] cyc_q, ins_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_q <= '0;
            ins_q <= '0;
        end else begin
            if (state_q != S_HALT) begin
                cyc_q <= cyc_q + 32'd1;
            end
            if ((state_d == S_FETCH) &&
                (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB})) begin
                ins_q <= ins_q + 32'd1;
            end
        end
    end

    assign cycleCount = cyc_q;
    assign instrCount = ins_q;
`else
    assign cycleCount = 32'd0;
    assign instrCount = 32'd0;
`endif

    // Everything is forced quiet while reset is held, dropping any pending request.
    assign memReq     = req_c  & ~reset;
    assign memWe      = we_c   & ~reset;
    assign memAddrSel = asel_c & ~reset;
    assign irWe       = ir_c   & ~reset;
    assign pcWe       = pc_c   & ~reset;
    assign pcSrcCtrl  = reset ? 2'd0 : pcs_c;
    assign abWe       = ab_c   & ~reset;
    assign aluOutWe   = ao_c   & ~reset;
    assign mdrWe      = mdr_c  & ~reset;
    assign regWe      = rw_c   & ~reset;
    assign regDInCtrl = reset ? 2'd0 : rdc_c;
    assign state      = reset ? 3'd0 : state_q;
    assign halted     = !reset && (state_q == S_HALT);
    assign haltCause  = reset ? CAUSE_NONE : cause_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected control words are queued
// from instruction plans and compared as the controller steps through them.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset, zero, memAck;
    logic [5:0]  opcode, funct;
    logic        memReq, memWe, memAddrSel, irWe, pcWe, abWe, aluOutWe, mdrWe, regWe, halted;
    logic [1:0]  pcSrcCtrl, regDInCtrl, haltCause;
    logic [2:0]  state;
    logic [31:0] cycleCount, instrCount;

    logic        wd_reset, wd_ack;
    logic        wd_memReq, wd_memWe, wd_memAddrSel, wd_irWe, wd_pcWe, wd_abWe, wd_aluOutWe;
    logic        wd_mdrWe, wd_regWe, wd_halted;
    logic [1:0]  wd_pcSrcCtrl, wd_regDInCtrl, wd_haltCause;
    logic [2:0]  wd_state;
    logic [31:0] wd_cycleCount, wd_instrCount;

`ifdef MULTICYCLE_CTRL_PERFCNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam int K_LW = 0, K_SW = 1, K_J = 2, K_JAL = 3, K_JR = 4;
    localparam int K_BEQ = 5, K_BNE = 6, K_ALU = 7, K_ILL = 8;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .memAck(memAck), .memReq(memReq), .memWe(memWe), .memAddrSel(memAddrSel),
        .irWe(irWe), .pcWe(pcWe), .pcSrcCtrl(pcSrcCtrl), .abWe(abWe),
        .aluOutWe(aluOutWe), .mdrWe(mdrWe), .regWe(regWe), .regDInCtrl(regDInCtrl),
        .state(state), .halted(halted), .haltCause(haltCause),
        .cycleCount(cycleCount), .instrCount(instrCount)
    );

    multicycle_ctrl #(.ACK_TIMEOUT(4), .TO_W(8)) dut_wd (
        .clk(clk), .reset(wd_reset), .opcode(opcode), .funct(funct), .zero(zero),
        .memAck(wd_ack), .memReq(wd_memReq), .memWe(wd_memWe), .memAddrSel(wd_memAddrSel),
        .irWe(wd_irWe), .pcWe(wd_pcWe), .pcSrcCtrl(wd_pcSrcCtrl), .abWe(wd_abWe),
        .aluOutWe(wd_aluOutWe), .mdrWe(wd_mdrWe), .regWe(wd_regWe),
        .regDInCtrl(wd_regDInCtrl), .state(wd_state), .halted(wd_halted),
        .haltCause(wd_haltCause), .cycleCount(wd_cycleCount), .instrCount(wd_instrCount)
    );

    // clock / reset
    always #5 clk = ~clk;

    // {state, memReq, memWe, memAddrSel, irWe, pcWe, pcSrcCtrl, abWe, aluOutWe, mdrWe, regWe, regDInCtrl, halted, haltCause}
    logic [18:0] obs;
    assign obs = {state, memReq, memWe, memAddrSel, irWe, pcWe, pcSrcCtrl, abWe,
                  aluOutWe, mdrWe, regWe, regDInCtrl, halted, haltCause};

    logic [18:0] exp_q[$];
    logic [13:0] stim_q[$];   // {opcode, funct, zero, memAck}
    int checks = 0, passes = 0, exp_cyc = 0, exp_instr = 0, cyc_no = 0;

    logic [11:0] legal_tab [12] = '{12'h8C0, 12'hAC0, 12'h080, 12'h0C0, 12'h100, 12'h140,
                                    12'h380, 12'h200, 12'h008, 12'h020, 12'h022, 12'h02A};

    function automatic logic [18:0] ew(input logic [2:0] st, input logic req, we, asel, ir, pc,
                                       input logic [1:0] pcs, input logic ab, ao, mdr, rw,
                                       input logic [1:0] rdc, input logic h, input logic [1:0] hc);
        return {st, req, we, asel, ir, pc, pcs, ab, ao, mdr, rw, rdc, h, hc};
    endfunction

    function automatic int kind_of(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h23: return K_LW;
            6'h2b: return K_SW;
            6'h02: return K_J;
            6'h03: return K_JAL;
            6'h04: return K_BEQ;
            6'h05: return K_BNE;
            6'h08, 6'h0e: return K_ALU;
            6'h00: begin
                case (fn)
                    6'h08: return K_JR;
                    6'h20, 6'h22, 6'h2a: return K_ALU;
                    default: return K_ILL;
                endcase
            end
            default: return K_ILL;
        endcase
    endfunction

    // driver: queue stimulus and expected words for one instruction
    task automatic plan(input logic [5:0] op, input logic [5:0] fn, input logic z,
                        input int fw, input int mw);
        int k = kind_of(op, fn);
        logic a, pc, rw;
        logic [1:0] pcs, rdc;
        for (int i = 0; i <= fw; i++) begin
            a = (i == fw);
            stim_q.push_back({op, fn, z, a});
            exp_q.push_back(ew(3'd0, 1, 0, 0, a, a, 2'd0, 0, 0, 0, 0, 2'd0, 0, 2'd0));
        end
        stim_q.push_back({op, fn, z, 1'($urandom_range(0, 1))});
        exp_q.push_back(ew(3'd1, 0, 0, 0, 0, 0, 2'd0, 1, 0, 0, 0, 2'd0, 0, 2'd0));
        if (k == K_ILL) return;
        pc = 0; pcs = 2'd0; rw = 0; rdc = 2'd0;
        case (k)
            K_J:   begin pc = 1; pcs = 2'd1; end
            K_JAL: begin pc = 1; pcs = 2'd1; rw = 1; rdc = 2'd2; end
            K_JR:  begin pc = 1; pcs = 2'd2; end
            K_BEQ: begin pc = z;  pcs = 2'd3; end
            K_BNE: begin pc = !z; pcs = 2'd3; end
            default: ;
        endcase
        stim_q.push_back({op, fn, z, 1'($urandom_range(0, 1))});
        exp_q.push_back(ew(3'd2, 0, 0, 0, 0, pc, pcs, 0, 1, 0, rw, rdc, 0, 2'd0));
        if (k == K_LW || k == K_SW) begin
            for (int i = 0; i <= mw; i++) begin
                a = (i == mw);
                stim_q.push_back({op, fn, z, a});
                exp_q.push_back(ew(3'd3, 1, k == K_SW, 1, 0, 0, 2'd0, 0, 0,
                                   (k == K_LW) && a, 0, 2'd0, 0, 2'd0));
            end
        end
        if (k == K_LW || k == K_ALU) begin
            stim_q.push_back({op, fn, z, 1'($urandom_range(0, 1))});
            exp_q.push_back(ew(3'd4, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 1,
                               (k == K_LW) ? 2'd1 : 2'd0, 0, 2'd0));
        end
        exp_instr++;
    endtask

    task automatic plan_halt(input logic [5:0] op, input logic [5:0] fn, input int n,
                             input logic [1:0] cause);
        for (int i = 0; i < n; i++) begin
            stim_q.push_back({op, fn, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))});
            exp_q.push_back(ew(3'd7, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 2'd0, 1, cause));
        end
    endtask

    // scoreboard: apply one stimulus per cycle, pop and compare its expected word
    task automatic drive_all();
        logic [18:0] e;
        while (stim_q.size() > 0) begin
            {opcode, funct, zero, memAck} = stim_q.pop_front();
            #1;
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) $display("FAIL ctl cyc%0d: got %h exp %h", cyc_no, obs, e);
            else passes++;
            if (e[18:16] != 3'd7) exp_cyc++;
            cyc_no++;
            @(negedge clk);
        end
    endtask

    task automatic check_counters(input string name);
        logic [31:0] ec, ei;
        ec = PERF ? 32'(exp_cyc) : 32'd0;
        ei = PERF ? 32'(exp_instr) : 32'd0;
        checks++;
        if (cycleCount !== ec) $display("FAIL %s cycleCount: got %0d exp %0d", name, cycleCount, ec);
        else passes++;
        checks++;
        if (instrCount !== ei) $display("FAIL %s instrCount: got %0d exp %0d", name, instrCount, ei);
        else passes++;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        memAck = 1'b0;
        #1;
        checks++;
        if (obs !== 19'd0) $display("FAIL reset_outputs: got %h exp 0", obs);
        else passes++;
        @(negedge clk);
        #1;
        checks++;
        if (cycleCount !== 32'd0 || instrCount !== 32'd0)
            $display("FAIL reset_counters: got %0d/%0d exp 0/0", cycleCount, instrCount);
        else passes++;
        reset = 1'b0;
        exp_cyc = 0;
        exp_instr = 0;
    endtask

    task automatic test_reset();
        apply_reset();
    endtask

    task automatic test_add();
        apply_reset();
        plan(6'h00, 6'h20, 1'b0, 0, 0);
        drive_all();
        check_counters("add");
        checks++;
        if (state !== 3'd0) $display("FAIL add_return_fetch: got %0d exp 0", state);
        else passes++;
    endtask

    task automatic test_lw_wait();
        apply_reset();
        plan(6'h23, 6'h15, 1'b1, 2, 2);
        plan(6'h2b, 6'h00, 1'b0, 1, 3);
        drive_all();
        check_counters("lw_sw_wait");
    endtask

    task automatic test_branch();
        plan(6'h04, 6'h00, 1'b0, 0, 0);
        plan(6'h05, 6'h00, 1'b0, 0, 0);
        plan(6'h04, 6'h3f, 1'b1, 0, 0);
        plan(6'h05, 6'h3f, 1'b1, 1, 0);
        drive_all();
        check_counters("branch");
    endtask

    task automatic test_jal();
        plan(6'h03, 6'h00, 1'b0, 0, 0);
        plan(6'h02, 6'h00, 1'b1, 0, 0);
        plan(6'h00, 6'h08, 1'b0, 0, 0);
        drive_all();
        check_counters("jump");
    endtask

    task automatic test_illegal();
        apply_reset();
        plan(6'h08, 6'h00, 1'b0, 0, 0);
        plan(6'h3f, 6'h00, 1'b0, 0, 0);
        plan_halt(6'h3f, 6'h00, 4, 2'd1);
        drive_all();
        check_counters("illegal_op");
        apply_reset();
        plan(6'h00, 6'h01, 1'b0, 1, 0);
        plan_halt(6'h00, 6'h01, 3, 2'd1);
        drive_all();
        check_counters("illegal_funct");
        apply_reset();
        plan(6'h0e, 6'h00, 1'b0, 0, 0);
        drive_all();
        check_counters("after_halt");
    endtask

    task automatic test_reset_mid();
        apply_reset();
        opcode = 6'h23;
        funct = 6'h00;
        memAck = 1'b1;
        @(negedge clk);
        memAck = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (state !== 3'd3 || memReq !== 1'b1) $display("FAIL mid_in_mem: got st%0d req%0b exp st3 req1", state, memReq);
        else passes++;
        reset = 1'b1;
        #1;
        checks++;
        if (state !== 3'd0 || memReq !== 1'b0) $display("FAIL mid_reset_quiet: got st%0d req%0b exp st0 req0", state, memReq);
        else passes++;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (state !== 3'd0 || memReq !== 1'b1) $display("FAIL mid_reset_fetch: got st%0d req%0b exp st0 req1", state, memReq);
        else passes++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [11:0] e;
        logic [5:0] op, fn;
        apply_reset();
        for (int n = 0; n < 16; n++) begin
            e = legal_tab[$urandom_range(0, 11)];
            op = e[11:6];
            fn = (op == 6'h00) ? e[5:0] : 6'($urandom_range(0, 63));
            plan(op, fn, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
        end
        drive_all();
        check_counters("back_to_back");
    endtask

    task automatic wd_to_mem();
        wd_reset = 1'b1;
        wd_ack = 1'b0;
        @(negedge clk);
        wd_reset = 1'b0;
        wd_ack = 1'b1;
        @(negedge clk);
        wd_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_timeout();
        opcode = 6'h23;
        funct = 6'h00;
        wd_to_mem();
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (wd_state !== 3'd3 || wd_halted !== 1'b0) $display("FAIL wd_wait%0d: got st%0d exp st3", i, wd_state);
            else passes++;
            @(negedge clk);
        end
        #1;
        checks++;
        if (wd_state !== 3'd7 || wd_halted !== 1'b1 || wd_haltCause !== 2'd2)
            $display("FAIL wd_mem_timeout: got st%0d cause%0d exp st7 cause2", wd_state, wd_haltCause);
        else passes++;
        wd_to_mem();
        for (int i = 0; i < 4; i++) begin
            wd_ack = (i == 3);
            #1;
            checks++;
            if (wd_state !== 3'd3) $display("FAIL wd_ack_wait%0d: got st%0d exp st3", i, wd_state);
            else passes++;
            @(negedge clk);
        end
        wd_ack = 1'b0;
        #1;
        checks++;
        if (wd_state !== 3'd4 || wd_haltCause !== 2'd0 || wd_regDInCtrl !== 2'd1)
            $display("FAIL wd_ack_wins: got st%0d cause%0d exp st4 cause0", wd_state, wd_haltCause);
        else passes++;
        wd_reset = 1'b1;
        @(negedge clk);
        wd_reset = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (wd_state !== 3'd7 || wd_haltCause !== 2'd2)
            $display("FAIL wd_fetch_timeout: got st%0d cause%0d exp st7 cause2", wd_state, wd_haltCause);
        else passes++;
        checks++;
        if (state === 3'd7) $display("FAIL no_wd_default: got st%0d exp not 7", state);
        else passes++;
    endtask

    initial begin
        reset = 1'b1;
        wd_reset = 1'b1;
        wd_ack = 1'b0;
        opcode = 6'h00;
        funct = 6'h00;
        zero = 1'b0;
        memAck = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_add();
        test_lw_wait();
        test_branch();
        test_jal();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        test_timeout();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencing controller for the MIPS-subset core. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB states and shares one unified memory port between instruction fetch and data access. It also generates the per-cycle write enables and mux selects for the PC, instruction register, register file and ALU-output/MDR latches. It sits between the instruction register and the datapath, alongside the instruction decoder.

## Interface
Parameters:
- `ACK_TIMEOUT`, default 0. Maximum cycles to wait for `memAck`. 0 disables the watchdog.
- `TO_W`, default 8. Width of the watchdog counter. Requires `ACK_TIMEOUT < 2**TO_W`.

Ports:
- `clk` in 1. Single clock; all state updates on the rising edge.
- `reset` in 1. Synchronous, active-high.
- `opcode` in 6. `instr[31:26]` from the instruction register.
- `funct` in 6. `instr[5:0]` from the instruction register.
- `zero` in 1. ALU zero flag, valid in EXEC.
- `memAck` in 1. Memory access complete.
- `memReq` out 1. Memory access request.
- `memWe` out 1. Request is a store.
- `memAddrSel` out 1. Address source: 0 = PC, 1 = ALU-out latch.
- `irWe` out 1. Load the instruction register.
- `pcWe` out 1. Load the PC.
- `pcSrcCtrl` out 2. PC source: 0 = PC+4, 1 = jump, 2 = JR, 3 = branch target.
- `abWe` out 1. Latch register-file read data A/B.
- `aluOutWe` out 1. Latch the ALU result.
- `mdrWe` out 1. Latch memory read data.
- `regWe` out 1. Register-file write.
- `regDInCtrl` out 2. Register write data: 0 = ALU, 1 = MDR, 2 = PC (JAL).
- `state` out 3. Current state, for debug.
- `halted` out 1. Controller is in HALT.
- `haltCause` out 2. 0 = none, 1 = illegal instruction, 2 = memory timeout.
- `cycleCount` out 32. Performance counter.
- `instrCount` out 32. Performance counter.

## Operation
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7. Codes 5 and 6 are unreachable; if entered, go to FETCH.
- Output default is 0 for every enable; `pcSrcCtrl`, `regDInCtrl` and `memAddrSel` default to 0.
- FETCH:
  - Drive `memReq`=1, `memAddrSel`=0.
  - On `memAck`: `irWe`=1, `pcWe`=1, `pcSrcCtrl`=0, go to DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - Drive `abWe`=1.
  - Legal opcodes: 0x23, 0x2b, 0x02, 0x03, 0x04, 0x05, 0x0e, 0x08, and 0x00 with funct in {0x08, 0x20, 0x22, 0x2a}.
  - Illegal instruction: go to HALT with `haltCause`=1. Otherwise go to EXEC.
- EXEC:
  - Drive `aluOutWe`=1.
  - J: `pcWe`=1, `pcSrcCtrl`=1, go to FETCH.
  - JAL: as J, plus `regWe`=1, `regDInCtrl`=2.
  - JR: `pcWe`=1, `pcSrcCtrl`=2, go to FETCH.
  - BEQ: `pcSrcCtrl`=3, `pcWe`=`zero`, go to FETCH.
  - BNE: `pcSrcCtrl`=3, `pcWe`=!`zero`, go to FETCH.
  - LW/SW: go to MEM.
  - ADD/SUB/SLT/ADDI/XORI: go to WB.
- MEM:
  - Drive `memReq`=1, `memAddrSel`=1, `memWe`=1 for SW.
  - On `memAck`: SW goes to FETCH; LW drives `mdrWe`=1 and goes to WB.
- WB:
  - Drive `regWe`=1; `regDInCtrl`=1 for LW, otherwise 0.
  - Go to FETCH.
- HALT: all enables 0, `halted`=1. Exit only via `reset`.
- Handshake rules:
  - `memReq`, `memWe` and `memAddrSel` depend on state only, so they are stable until ack.
  - `memAck` is sampled only while `memReq`=1; ack in the same cycle as the request is legal.
  - `memAck` in any other state is ignored.
- Watchdog (only when `ACK_TIMEOUT`>0):
  - The counter clears on entry to FETCH or MEM and increments each cycle `memReq`=1 && !`memAck`.
  - When it reaches `ACK_TIMEOUT` without ack, go to HALT with `haltCause`=2.
  - Ack in the same cycle the limit is reached wins: proceed normally.

## Timing
- Reset:
  - While `reset`=1, `state`=FETCH and all enables are forced 0, including `memReq`.
  - Also on reset: `halted`=0, `haltCause`=0, counters=0, watchdog=0.
  - The first cycle after deassertion is FETCH with `memReq`=1.
  - Reset asserted mid-instruction or in HALT takes effect at the next edge, abandoning any outstanding request.
- Output decode:
  - Enables are combinational from state.
  - FETCH `irWe`/`pcWe`, MEM `mdrWe`, and branch `pcWe` are also combinational on `memAck`/`zero`.
- Latency with zero-wait memory:
  - J/JAL/JR/BEQ/BNE: 3 cycles.
  - R-type ALU, ADDI, XORI: 4 cycles.
  - SW: 4 cycles.
  - LW: 5 cycles.
  - Each wait cycle adds 1 cycle.

## Configuration
- `MULTICYCLE_CTRL_PERFCNT_EN` defined:
  - `cycleCount` increments every cycle not in reset and not in HALT.
  - `instrCount` increments on every transition into FETCH from DECODE/EXEC/MEM/WB (instruction retired).
  - Both are 32-bit and wrap from 0xFFFFFFFF to 0.
- Undefined: the counters are not built, and `cycleCount` and `instrCount` are tied to 0.

## Test plan
- Zero-wait ADD (opcode 0x00, funct 0x20) after reset → states 0,1,2,4,0. `regWe`=1 only in WB. `instrCount`=1 after 4 cycles.
- LW with `memAck` delayed 2 cycles in both FETCH and MEM → 9 cycles total. `mdrWe` pulses once in MEM. WB has `regDInCtrl`=1.
- BEQ with `zero`=0, then BNE with `zero`=0 → BEQ `pcWe`=0 in EXEC; BNE `pcWe`=1 with `pcSrcCtrl`=3. Each takes 3 cycles.
- JAL → EXEC asserts `pcWe`=1, `pcSrcCtrl`=1, `regWe`=1, `regDInCtrl`=2.
- Illegal opcode 0x3f, or funct 0x01 with opcode 0x00 → HALT after DECODE. `halted`=1, `haltCause`=1. Counters freeze. `reset` returns to FETCH.
- `ACK_TIMEOUT`=4 with `memAck` held 0 in MEM → HALT with `haltCause`=2 exactly 4 wait cycles after MEM entry. Rerun with ack on the 4th cycle → no halt.
